uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data bus next to the data RAM and consumes CPU store traffic addressed to it. Bytes written by software go into a TX FIFO and are serialised 8N1, LSB first, on `txd` at a programmable bit period. A status register lets polling code check FIFO level and idle state. An optional interrupt output is also provided.

---
 rtl/uart_tx_mmio_if.sv | 14 +
 rtl/uart_tx_mmio.sv | 122 ++++++++++++
 tb/tb_uart_tx_mmio.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-bus slice seen by the UART transmitter.
//   sel/addr/read/write/wdata/byteenable come from the CPU side (master),
//   data is the combinational read data returned by the peripheral (slave).
interface uart_tx_mmio_if;
  logic        sel;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  byteenable;
  logic [31:0] data;
  modport master (output sel, addr, read, write, wdata, byteenable, input data);
  modport slave  (input sel, addr, read, write, wdata, byteenable, output data);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO.
//   clock, reset : single clock, synchronous active-high reset
//   dbus         : CPU bus slave (TXDATA/STATUS/DIVISOR/CTRL at addr[3:2])
//   txd          : serial output, idles high
//   irq          : idle-and-empty interrupt, only when UART_TX_IRQ_EN is defined
module uart_tx_mmio #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_mmio_if.slave        dbus,
  output logic                 txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state, state_nx;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [15:0]     divisor, div_eff, bit_cnt;
  logic [2:0]      idx;
  logic [7:0]      shifter;
  logic [1:0]      reg_sel;
  logic [31:0]     status;
  logic            wr, rd, full, empty, push_req, push, pop, can_start, bit_done, busy;
  logic            tx_enable, ovf, irq_enable, irq_pend, unused;
  assign reg_sel   = dbus.addr[3:2];
  assign wr        = dbus.sel && dbus.write;
  assign rd        = dbus.sel && dbus.read;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign push_req  = wr && reg_sel == 2'd0 && dbus.byteenable[0];
  // full is the registered value, so a same-cycle pop never rescues a push
  assign push      = push_req && !full;
  assign can_start = !empty && tx_enable;
  assign div_eff   = divisor == 16'd0 ? 16'd1 : divisor;
  assign bit_done  = bit_cnt == 16'd1;
  assign unused    = ^{dbus.addr[31:4], dbus.addr[1:0], dbus.wdata[31:16], dbus.wdata[2], dbus.byteenable[3:2]};
  always_ff @(posedge clock)
    if (push) mem[wptr] <= dbus.wdata[7:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      divisor   <= 16'(CLK_DIV);
      tx_enable <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      if (wr && reg_sel == 2'd2 && dbus.byteenable[1:0] == 2'b11) divisor <= dbus.wdata[15:0];
      if (wr && reg_sel == 2'd3) tx_enable <= dbus.wdata[0];
      if (wr && reg_sel == 2'd3 && dbus.wdata[1]) ovf <= 1'b0;
      if (push_req && full) ovf <= 1'b1;
    end
  end
`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr && reg_sel == 2'd3) irq_enable <= dbus.wdata[2];
      irq <= irq_enable && irq_pend;
    end
  end
  assign irq_pend = empty && state == IDLE;
`else
  assign irq_enable = 1'b0;
  assign irq_pend   = 1'b0;
`endif
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (can_start ? START : IDLE) :
               !bit_done      ? state :
               state == START ? DATA :
               state == DATA  ? (idx == 3'd7 ? STOP : DATA) :
               (can_start ? START : IDLE);
  always_comb begin
    busy = state != IDLE;
    pop  = can_start && (state == IDLE || (state == STOP && bit_done));
    txd  = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
  end
  // the baud counter reloads from DIVISOR only at bit boundaries, so a
  // divisor write never disturbs the bit currently on the line
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= '0;
      idx     <= '0;
      shifter <= '0;
    end else begin
      if (pop) begin
        shifter <= mem[rptr];
        bit_cnt <= div_eff;
      end else if (busy) begin
        bit_cnt <= bit_done ? div_eff : bit_cnt - 16'd1;
      end
      if (state == DATA && bit_done) begin
        shifter <= shifter >> 1;
        idx     <= idx + 1'b1;
      end
    end
  end
  assign status    = {16'h0, 8'(count), 3'b0, irq_pend, ovf, busy, empty, full};
  assign dbus.data = !rd             ? 32'h0 :
                     reg_sel == 2'd1 ? status :
                     reg_sel == 2'd2 ? {16'h0, divisor} :
                     reg_sel == 2'd3 ? {29'h0, irq_enable, 1'b0, tx_enable} : 32'h0;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio.
module tb_uart_tx_mmio;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic txd;
`ifdef UART_TX_IRQ_EN
  logic irq;
  localparam logic [31:0] IP = 32'h10;
  localparam logic [31:0] CTRL_IRQ = 32'h5;
`else
  localparam logic [31:0] IP = 32'h0;
  localparam logic [31:0] CTRL_IRQ = 32'h1;
`endif
  int checks = 0;
  int errors = 0;
  int mism;
  logic [31:0] d;
  logic [9:0]  fr;
  logic [7:0]  bytes [3];
  logic        t0;
  uart_tx_mmio_if dbus();
  uart_tx_mmio #(.CLK_DIV(434), .FIFO_DEPTH(16)) dut (
    .clock(clock),
    .reset(reset),
    .dbus(dbus),
    .txd(txd)
`ifdef UART_TX_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] be);
    @(negedge clock);
    dbus.sel = 1'b1;
    dbus.write = 1'b1;
    dbus.addr = {28'h0, a, 2'b00};
    dbus.wdata = v;
    dbus.byteenable = be;
    @(negedge clock);
    dbus.sel = 1'b0;
    dbus.write = 1'b0;
    dbus.byteenable = 4'h0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    dbus.sel = 1'b1;
    dbus.read = 1'b1;
    dbus.addr = {28'h0, a, 2'b00};
    #1 v = dbus.data;
    dbus.sel = 1'b0;
    dbus.read = 1'b0;
  endtask
  initial begin
    dbus.sel = 1'b0;
    dbus.read = 1'b0;
    dbus.write = 1'b0;
    dbus.addr = 32'h0;
    dbus.wdata = 32'h0;
    dbus.byteenable = 4'h0;
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    // reset state and register map
    rd(2'd1, d); check("rst_status", d, 32'h2 | IP);
    check("rst_txd", txd, 1'b1);
    rd(2'd2, d); check("rst_divisor", d, 32'd434);
    rd(2'd3, d); check("rst_ctrl", d, 32'h1);
    rd(2'd0, d); check("txdata_reads0", d, 32'h0);
    dbus.sel = 1'b1; dbus.addr = 32'h4;
    #1 check("no_read_strobe", dbus.data, 32'h0);
    dbus.sel = 1'b0;
    wr(2'd0, 32'h55, 4'b1110);
    rd(2'd1, d); check("lane0_required", d, 32'h2 | IP);
    wr(2'd2, 32'h7, 4'b0001);
    rd(2'd2, d); check("div_lanes_required", d, 32'd434);
    wr(2'd3, 32'h5, 4'hF);
    rd(2'd3, d); check("ctrl_irq_bit", d, CTRL_IRQ);
    wr(2'd3, 32'h1, 4'hF);
    // single frame 0xA5 at divisor 4
    wr(2'd2, 32'h4, 4'hF);
    wr(2'd0, 32'hA5, 4'h1);
    check("a5_before_start", txd, 1'b1);
    @(negedge clock);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d", k), txd, fr[k]);
      if (k < 9) repeat (4) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    rd(2'd1, d); check("a5_busy_last", d, 32'h6);
    @(negedge clock);
    rd(2'd1, d); check("a5_idle_after", d, 32'h2 | IP);
    // three back-to-back frames
    @(negedge clock);
    dbus.sel = 1'b1; dbus.write = 1'b1; dbus.addr = 32'h0; dbus.byteenable = 4'h1; dbus.wdata = 32'h11;
    @(negedge clock);
    dbus.wdata = 32'h22;
    @(negedge clock);
    dbus.wdata = 32'h33;
    t0 = txd;
    @(negedge clock);
    dbus.sel = 1'b0; dbus.write = 1'b0; dbus.byteenable = 4'h0;
    mism = (t0 !== 1'b0) ? 1 : 0;
    rd(2'd1, d); check("burst_cnt2", {24'h0, d[15:8]}, 32'd2);
    for (int c = 1; c < 120; c++) begin
      fr = {1'b1, bytes[c / 40], 1'b0};
      if (txd !== fr[(c % 40) / 4]) mism++;
      if (c == 40) begin rd(2'd1, d); check("burst_cnt1", {24'h0, d[15:8]}, 32'd1); end
      if (c == 80) begin rd(2'd1, d); check("burst_cnt0", {24'h0, d[15:8]}, 32'd0); end
      @(negedge clock);
    end
    check("burst_txd_mismatches", mism, 32'd0);
    rd(2'd1, d); check("burst_idle", d, 32'h2 | IP);
    // overflow with transmitter disabled
    wr(2'd3, 32'h0, 4'hF);
    for (int i = 0; i < 17; i++) wr(2'd0, 32'(i), 4'h1);
    rd(2'd1, d); check("ovf_status", d, 32'h1009);
    check("ovf_txd_idle", txd, 1'b1);
    wr(2'd3, 32'h3, 4'hF);
    rd(2'd1, d); check("clr_ovf_status", d, 32'h1001);
    rd(2'd3, d); check("clr_ovf_reads0", d, 32'h1);
    @(negedge clock);
    rd(2'd1, d); check("enable_starts", d, 32'h0F04);
    check("enable_txd_low", txd, 1'b0);
    // reset in the middle of a frame
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_txd", txd, 1'b1);
    rd(2'd1, d); check("midrst_status", d, 32'h2 | IP);
    rd(2'd2, d); check("midrst_divisor", d, 32'd434);
    reset = 1'b0;
    // divisor change 4 -> 2 during the start bit
    wr(2'd2, 32'h4, 4'hF);
    wr(2'd0, 32'h0F, 4'h1);
    wr(2'd2, 32'h2, 4'hF);
    repeat (2) @(negedge clock);
    check("div_start_kept", txd, 1'b0);
    @(negedge clock);
    check("div_d0", txd, 1'b1);
    repeat (7) @(negedge clock);
    check("div_d3_end", txd, 1'b1);
    @(negedge clock);
    check("div_d4", txd, 1'b0);
    repeat (9) @(negedge clock);
    rd(2'd1, d); check("div_stop_busy", d, 32'h6);
    @(negedge clock);
    rd(2'd1, d); check("div_idle", d, 32'h2 | IP);
`ifdef UART_TX_IRQ_EN
    wr(2'd3, 32'h5, 4'hF);
    @(negedge clock);
    check("irq_idle", irq, 1'b1);
    wr(2'd0, 32'h81, 4'h1);
    check("irq_push_edge", irq, 1'b1);
    @(negedge clock);
    check("irq_after_push", irq, 1'b0);
    repeat (20) @(negedge clock);
    check("irq_stop_end", irq, 1'b0);
    @(negedge clock);
    check("irq_reassert", irq, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
